// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from NUM_REQ requesters to one UART transmitter.
// Define UART_ARB_HDR_EN to send a {4'hA, grant_id} header byte before each data byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int STARTUP_CYCLES = 2,
  parameter int ACK_TIMEOUT    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_din,
  output logic                 tx_en,
  input  logic                 tx_ready,
  output logic [3:0]           grant_id,
  output logic                 busy
);

`ifdef UART_ARB_HDR_EN
  typedef enum logic [2:0] {
    INIT, ARB, ISSUE, WAIT_LO, WAIT_HI,
    ISSUE_HDR, WAIT_HDR_LO, WAIT_HDR_HI
  } state_t;
`else
  typedef enum logic [2:0] {
    INIT, ARB, ISSUE, WAIT_LO, WAIT_HI
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        retry_q, retry_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  last_q, last_d;
  logic [7:0]  data_q, data_d;

  logic        found;
  int          sel;
  int          idx;

  // Search starts just after the last winner so nobody starves.
  always_comb begin
    found = 1'b0;
    sel   = 0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && |(req_valid & (NUM_REQ'(1) << idx))) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      retry_q <= 1'b0;
      grant_q <= '0;
      last_q  <= 4'(NUM_REQ - 1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    grant_d   = grant_q;
    last_d    = last_q;
    data_d    = data_q;
    tx_en     = 1'b0;
    tx_din    = 8'h00;
    req_ready = '0;
    unique case (state_q)
      INIT: begin
        if (int'(cnt_q) + 1 >= STARTUP_CYCLES) begin
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ARB: begin
        if (tx_ready && found) begin
          grant_d = 4'(sel);
          last_d  = 4'(sel);
          data_d  = 8'(req_data >> (8 * sel));
          retry_d = 1'b0;
`ifdef UART_ARB_HDR_EN
          state_d = ISSUE_HDR;
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        if (tx_ready) begin
          tx_en  = 1'b1;
          tx_din = data_q;
          if (!retry_q) req_ready = NUM_REQ'(1) << grant_q;
          cnt_d   = '0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_ready) begin
          state_d = WAIT_HI;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          retry_d = 1'b1;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_HI: begin
        if (tx_ready) state_d = ARB;
      end
`ifdef UART_ARB_HDR_EN
      ISSUE_HDR: begin
        if (tx_ready) begin
          tx_en   = 1'b1;
          tx_din  = {4'hA, grant_q};
          cnt_d   = '0;
          state_d = WAIT_HDR_LO;
        end
      end
      WAIT_HDR_LO: begin
        if (!tx_ready) begin
          state_d = WAIT_HDR_HI;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          state_d = ISSUE_HDR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_HDR_HI: begin
        if (tx_ready) state_d = ISSUE;
      end
`endif
      default: state_d = INIT;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != INIT) && (state_q != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART transmitter model.
// Protocol rules are tallied every cycle and compared at the end.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_din;
  logic        tx_en;
  logic        tx_ready = 1'b1;
  logic [3:0]  grant_id;
  logic        busy;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_din(tx_din),
    .tx_en(tx_en), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy 3 cycles per byte, can drop the first strobe.
  int   bcnt = 0;
  logic ign_en = 1'b0;
  logic ign_done = 1'b0;
  always @(posedge clk) begin
    if (!ign_en) ign_done <= 1'b0;
    if (tx_en) begin
      if (ign_en && !ign_done) begin
        ign_done <= 1'b1;
      end else begin
        tx_ready <= 1'b0;
        bcnt     <= 3;
      end
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_ready <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q_din[$];
  logic [3:0] q_rr[$];
  int         q_cyc[$];
  int v_b2b = 0, v_rdy = 0, v_oh = 0, v_rr = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (tx_en) begin
      q_din.push_back(tx_din);
      q_rr.push_back(req_ready);
      q_cyc.push_back(cyc);
    end
    if (tx_en && prev_en) v_b2b++;
    if (tx_en && !tx_ready) v_rdy++;
    if ($countones(req_ready) > 1) v_oh++;
    if (req_ready != 0 && !tx_en) v_rr++;
    prev_en = tx_en;
  end

  int rel = 0;

  task automatic do_reset(input bit chk_vals);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if (chk_vals) begin
      chk("rst_tx_en", tx_en, 0);
      chk("rst_tx_din", tx_din, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
    end
    q_din.delete();
    q_rr.delete();
    q_cyc.delete();
    rst = 1'b0;
    rel = cyc;
  endtask

  task automatic wait_tx(input int n, input int bound);
    for (int i = 0; i < bound && q_din.size() < n; i++)
      @(negedge clk);
    chk("tx_timeout", 32'(q_din.size() >= n), 1);
  endtask

  initial begin
`ifdef UART_ARB_HDR_EN
    do_reset(1'b1);
    req_valid = 4'b0010;
    req_data  = 32'h0000_C300;
    wait_tx(2, 60);
    req_valid = '0;
    if (q_din.size() >= 2) begin
      chk("hdr_byte", q_din[0], 8'hA1);
      chk("hdr_rr", q_rr[0], 4'b0000);
      chk("hdr_data", q_din[1], 8'hC3);
      chk("hdr_data_rr", q_rr[1], 4'b0010);
    end
    repeat (20) @(negedge clk);
    chk("hdr_count", q_din.size(), 2);
    chk("hdr_grant", grant_id, 1);
`else
    // Single requester
    do_reset(1'b1);
    req_valid = 4'b0100;
    req_data  = 32'h005A_0000;
    wait_tx(1, 30);
    req_valid = '0;
    chk("s1_grant", grant_id, 2);
    chk("s1_busy", busy, 1);
    if (q_din.size() >= 1) begin
      chk("s1_din", q_din[0], 8'h5A);
      chk("s1_rr", q_rr[0], 4'b0100);
      chk("s1_lat", q_cyc[0] - rel, 3);
    end
    repeat (20) @(negedge clk);
    chk("s1_count", q_din.size(), 1);
    chk("s1_idle", busy, 0);

    // All four held: round robin order and spacing
    do_reset(1'b0);
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    wait_tx(5, 80);
    req_valid = '0;
    if (q_din.size() >= 5) begin
      chk("s2_b0", q_din[0], 8'h10);
      chk("s2_b1", q_din[1], 8'h11);
      chk("s2_b2", q_din[2], 8'h12);
      chk("s2_b3", q_din[3], 8'h13);
      chk("s2_b4", q_din[4], 8'h10);
      chk("s2_rr0", q_rr[0], 4'b0001);
      chk("s2_rr3", q_rr[3], 4'b1000);
      chk("s2_rr4", q_rr[4], 4'b0001);
      for (int i = 1; i < 5; i++)
        chk("s2_gap", q_cyc[i] - q_cyc[i-1], 6);
    end
    repeat (20) @(negedge clk);

    // Transmitter ignores the first strobe
    do_reset(1'b0);
    ign_en    = 1'b1;
    req_valid = 4'b0010;
    req_data  = 32'h0000_7700;
    wait_tx(1, 30);
    req_valid = '0;
    wait_tx(2, 30);
    if (q_din.size() >= 2) begin
      chk("s3_din0", q_din[0], 8'h77);
      chk("s3_din1", q_din[1], 8'h77);
      chk("s3_rr0", q_rr[0], 4'b0010);
      chk("s3_rr1", q_rr[1], 4'b0000);
      chk("s3_gap", q_cyc[1] - q_cyc[0], 4);
    end
    repeat (20) @(negedge clk);
    chk("s3_count", q_din.size(), 2);
    ign_en = 1'b0;

    // Reset during WAIT_LO
    do_reset(1'b0);
    req_valid = 4'b0001;
    req_data  = 32'h0000_0042;
    wait_tx(1, 30);
    if (q_cyc.size() >= 1)
      while (cyc < q_cyc[0] + 1) @(negedge clk);
    chk("s4_busy", busy, 1);
    chk("s4_txrdy", tx_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("s4_en", tx_en, 0);
    chk("s4_din", tx_din, 0);
    chk("s4_rr", req_ready, 0);
    chk("s4_grant", grant_id, 0);
    chk("s4_bsy0", busy, 0);
    @(negedge clk);
    q_din.delete();
    q_rr.delete();
    q_cyc.delete();
    rst = 1'b0;
    rel = cyc;
    wait_tx(1, 30);
    req_valid = '0;
    if (q_din.size() >= 1) begin
      chk("s4_restart", q_cyc[0] - rel, 3);
      chk("s4_din2", q_din[0], 8'h42);
    end
    repeat (20) @(negedge clk);
`endif
    chk("a_b2b", v_b2b, 0);
    chk("a_rdy", v_rdy, 0);
    chk("a_onehot", v_oh, 0);
    chk("a_rr_wo_en", v_rr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 Parameter STARTUP_CYCLES, default 2, idle cycles after reset before the first tx_en.
REQ-003 Parameter ACK_TIMEOUT, default 3, cycles allowed for tx_ready to fall after tx_en.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte pending; held until its req_ready.
REQ-007 req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i]; stable while req_valid.
REQ-008 req_ready  output  NUM_REQ  one-cycle pulse; byte of requester i accepted.
REQ-009 tx_din  output  8  byte to UART transmitter.
REQ-010 tx_en  output  1  one-cycle send strobe to UART transmitter.
REQ-011 tx_ready  input  1  UART transmitter idle flag (high = can accept).
REQ-012 grant_id  output  4  index of requester currently or last served.
REQ-013 busy  output  1  high from grant until the transmitter returns ready.

Function
REQ-014 FSM states SHALL be INIT, ARB, ISSUE, WAIT_LO, WAIT_HI; optional HDR states per REQ-027.
REQ-015 INIT SHALL last STARTUP_CYCLES cycles, then go to ARB.
REQ-016 ARB SHALL wait for tx_ready=1 and any req_valid bit; else stay.
REQ-017 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NUM_REQ, first valid wins.
REQ-018 On grant, grant_id and last_grant SHALL update, the byte SHALL be latched, busy SHALL rise, and the FSM SHALL go to ISSUE.
REQ-019 ISSUE SHALL drive tx_din=latched byte and pulse tx_en for exactly one cycle; req_ready[grant_id] SHALL pulse in the same cycle.
REQ-020 WAIT_LO SHALL wait for tx_ready=0, then go to WAIT_HI.
REQ-021 If tx_ready stays 1 for ACK_TIMEOUT cycles in WAIT_LO, tx_en SHALL re-pulse with the same tx_din and the wait SHALL restart; req_ready SHALL NOT re-pulse.
REQ-022 WAIT_HI SHALL wait for tx_ready=1, then drop busy and return to ARB; the next tx_en SHALL occur no earlier than 2 cycles after tx_ready rises.
REQ-023 tx_en SHALL never be asserted in consecutive cycles, nor while tx_ready=0.
REQ-024 req_valid changes during ISSUE/WAIT states SHALL NOT affect the byte in flight; a requester deasserting before req_ready SHALL simply lose arbitration.
REQ-025 Simultaneous requests: at most one req_ready bit high per cycle; no requester starves beyond NUM_REQ-1 grants of others.
REQ-026 Timeout counter SHALL be 4 bits minimum and saturate-free (cleared on each tx_en).

Configuration
REQ-027 Macro UART_ARB_HDR_EN defined: each grant SHALL first send header byte {4'hA, grant_id} through ISSUE_HDR/WAIT_HDR_LO/WAIT_HDR_HI states, then the data byte; req_ready pulses with the data tx_en only.
REQ-028 UART_ARB_HDR_EN undefined: no header; one UART byte per grant; HDR states absent.

Reset
REQ-029 On rst: tx_en=0, tx_din=8'h00, req_ready=0, grant_id=0, busy=0, FSM=INIT, last_grant=NUM_REQ-1 (requester 0 first).
REQ-030 rst mid-transfer SHALL abort immediately with no further tx_en; no req_ready pulse for the aborted byte.

Verification
REQ-031 Single: req_valid=4'b0100, data2=8'h5A -> after INIT, tx_en once with tx_din=8'h5A, req_ready=4'b0100 same cycle, grant_id=2.
REQ-032 All four valid with 8'h10..8'h13 held -> tx bytes in order 10,11,12,13 then 10; each send after tx_ready returns high.
REQ-033 Transmitter model ignoring first tx_en (tx_ready stays 1) -> tx_en re-pulses after 3 cycles, same byte, single req_ready.
REQ-034 rst asserted during WAIT_LO -> next cycle all outputs at reset values; no tx_en for STARTUP_CYCLES cycles after release.
REQ-035 UART_ARB_HDR_EN defined, req 1 byte 8'hC3 -> tx bytes 8'hA1 then 8'hC3; req_ready[1] pulses with second tx_en only.
REQ-036 Continuous assertion checks: tx_en never two cycles in a row; tx_en never with tx_ready=0; req_ready onehot-or-zero.
